// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the CPU debug-slave port and
// the JTAG command stream. JTAG commands are captured into a one-deep pending
// slot, executed with an auto-incrementing address, and reported back through
// monitor_ready / monitor_error. The two requesters alternate when they collide.
module nios2_ocimem_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU debug-slave port
    input  logic [ADDR_WIDTH-1:0] avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    input  logic [3:0]            avs_byteenable,
    output logic [31:0]           avs_readdata,
    output logic                  avs_waitrequest,
    // JTAG command stream
    input  logic [37:0]           jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_no_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    output logic [31:0]           MonDReg,
    output logic [ADDR_WIDTH-1:0] MonAReg,
    output logic                  monitor_ready,
    output logic                  monitor_error,
    // OCI RAM
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    output logic                  ram_wren,
    output logic [3:0]            ram_byteenable,
    output logic [31:0]           ram_wrdata,
    input  logic [31:0]           ram_rddata
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_DATA = 1'b1
    } state_t;

    state_t      state;
    logic        jtag_pending;
    logic        jtag_is_write;
    logic [31:0] jtag_wrdata;
    logic        last_grant_jtag;  // 0: CPU was granted last
    logic        rd_jtag;          // owner of the read in RD_DATA

    logic cpu_req;
    logic in_idle;
    logic rd_phase;
    logic grant_cpu;
    logic grant_jtag;
    logic start_rd;
    logic cpu_rd_done;
    logic jtag_rd_done;
    logic jtag_wr_done;
    logic any_pulse;

    // jdo bits outside the address and data fields carry nothing for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign cpu_req  = avs_read | avs_write;
    assign in_idle  = (state == IDLE) & ~reset;
    assign rd_phase = (state == RD_DATA) & ~reset;

    // JTAG wins a tie only when the CPU had the previous grant
    assign grant_jtag = in_idle & jtag_pending & (~cpu_req | ~last_grant_jtag);
    assign grant_cpu  = in_idle & cpu_req & ~grant_jtag;

    assign start_rd     = (grant_cpu & ~avs_write) | (grant_jtag & ~jtag_is_write);
    assign cpu_rd_done  = rd_phase & ~rd_jtag;
    assign jtag_rd_done = rd_phase & rd_jtag;
    assign jtag_wr_done = grant_jtag & jtag_is_write;
    assign any_pulse    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    assign monitor_ready   = ~jtag_pending;
    assign avs_waitrequest = reset | (cpu_req & ~((grant_cpu & avs_write) | cpu_rd_done));
    assign avs_readdata    = cpu_rd_done ? ram_rddata : 32'h0;

    // RAM port driven straight from the grant so CPU writes finish with no stall
    always_comb begin
        ram_address    = MonAReg;
        ram_rden       = 1'b0;
        ram_wren       = 1'b0;
        ram_byteenable = 4'h0;
        ram_wrdata     = 32'h0;
        if (grant_cpu) begin
            ram_address    = avs_address;
            ram_wren       = avs_write;
            ram_rden       = ~avs_write;
            ram_byteenable = avs_byteenable;
            ram_wrdata     = avs_writedata;
        end else if (grant_jtag) begin
            ram_address    = MonAReg;
            ram_wren       = jtag_is_write;
            ram_rden       = ~jtag_is_write;
            ram_byteenable = 4'hF;
            ram_wrdata     = jtag_wrdata;
        end
    end

    // Sequencer state, JTAG command slot, address/data monitors and fairness
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            rd_jtag         <= 1'b0;
            last_grant_jtag <= 1'b0;
            jtag_pending    <= 1'b0;
            jtag_is_write   <= 1'b0;
            jtag_wrdata     <= 32'h0;
            monitor_error   <= 1'b0;
            MonAReg         <= '0;
            MonDReg         <= 32'h0;
        end else begin
            if (start_rd) begin
                state   <= RD_DATA;
                rd_jtag <= grant_jtag;
            end else begin
                state   <= IDLE;
            end

            if (grant_jtag) begin
                last_grant_jtag <= 1'b1;
                MonAReg         <= MonAReg + ADDR_WIDTH'(1);
            end else if (grant_cpu) begin
                last_grant_jtag <= 1'b0;
            end

            if (jtag_rd_done)
                MonDReg <= ram_rddata;

            // Pending clears only at the completing edge, so a pulse on that
            // same edge still sees the slot busy and is dropped
            if (jtag_pending) begin
                if (jtag_rd_done | jtag_wr_done)
                    jtag_pending <= 1'b0;
                if (any_pulse)
                    monitor_error <= 1'b1;
            end else if (take_action_ocimem_a) begin
                MonAReg       <= jdo[ADDR_WIDTH+25:26];
                monitor_error <= 1'b0;
                jtag_pending  <= 1'b1;
                jtag_is_write <= 1'b0;
            end else if (take_action_ocimem_b) begin
                jtag_pending  <= 1'b1;
                jtag_is_write <= 1'b1;
                jtag_wrdata   <= jdo[34:3];
            end else if (take_no_action_ocimem_a) begin
                jtag_pending  <= 1'b1;
                jtag_is_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter with a behavioural OCI RAM.
// Expected RAM accesses and read data are queued as stimulus is driven and
// checked when the DUT strobes the RAM or completes a read.
module tb_nios2_ocimem_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;
    logic [37:0]   jdo;
    logic          take_action_ocimem_a;
    logic          take_no_action_ocimem_a;
    logic          take_action_ocimem_b;
    logic [31:0]   MonDReg;
    logic [AW-1:0] MonAReg;
    logic          monitor_ready;
    logic          monitor_error;
    logic [AW-1:0] ram_address;
    logic          ram_rden;
    logic          ram_wren;
    logic [3:0]    ram_byteenable;
    logic [31:0]   ram_wrdata;
    logic [31:0]   ram_rddata;

    nios2_ocimem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .ram_address             (ram_address),
        .ram_rden                (ram_rden),
        .ram_wren                (ram_wren),
        .ram_byteenable          (ram_byteenable),
        .ram_wrdata              (ram_wrdata),
        .ram_rddata              (ram_rddata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   data;
    } acc_t;

    int          checks = 0;
    int          errors = 0;
    acc_t        ram_q[$];
    logic [31:0] jq[$];
    logic [31:0] cq[$];
    logic [31:0] refm [256];
    acc_t        mon_e;

    function automatic logic [31:0] init_val(int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Behavioural single-port RAM, one-cycle read latency
    logic [31:0] mem [256];
    logic [31:0] rd_q;
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            rd_q      <= 32'h0;
            mem_ready <= 1'b1;
        end else begin
            if (ram_wren)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_wrdata[8*b +: 8];
            if (ram_rden) rd_q <= mem[ram_address];
        end
    end
    assign ram_rddata = rd_q;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every RAM strobe must match the next queued access
    always @(negedge clk) begin
        if (ram_rden === 1'b1 || ram_wren === 1'b1) begin
            if (ram_q.size() == 0) begin
                chk("ram_unexpected_strobe", 64'({ram_wren, ram_rden, ram_address}), 64'd0);
            end else begin
                mon_e = ram_q.pop_front();
                chk("ram_op", 64'({ram_wren, ram_rden, ram_address}),
                    64'({mon_e.wr, ~mon_e.wr, mon_e.addr}));
                if (mon_e.wr)
                    chk("ram_wdata", 64'({ram_byteenable, ram_wrdata}), 64'({mon_e.be, mon_e.data}));
            end
        end
    end

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic push_rd(logic [AW-1:0] a);
        ram_q.push_back({1'b0, a, 4'h0, 32'h0});
    endtask

    task automatic push_wr(logic [AW-1:0] a, logic [3:0] be, logic [31:0] d);
        ram_q.push_back({1'b1, a, be, d});
        for (int b = 0; b < 4; b++)
            if (be[b]) refm[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic push_jrd(logic [AW-1:0] a); jq.push_back(refm[a]); endtask
    task automatic push_crd(logic [AW-1:0] a); cq.push_back(refm[a]); endtask

    task automatic chk_jrd(string tag);
        logic [31:0] e;
        e = (jq.size() > 0) ? jq.pop_front() : 32'hxxxx_xxxx;
        chk(tag, 64'(MonDReg), 64'(e));
    endtask

    task automatic chk_crd(string tag);
        logic [31:0] e;
        e = (cq.size() > 0) ? cq.pop_front() : 32'hxxxx_xxxx;
        chk(tag, 64'(avs_readdata), 64'(e));
    endtask

    // kind 0: action_a (load address), 1: action_b (write), 2: no_action_a
    task automatic set_jtag(int kind, logic [AW-1:0] a, logic [31:0] d);
        jdo = '0;
        if (kind == 1) jdo[34:3] = d;
        else           jdo[AW+25:26] = a;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
    endtask

    task automatic clr_jtag();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    // Bounded wait for monitor_ready; returns at the start of a fresh cycle
    task automatic wait_ready(string tag);
        int n;
        n = 0;
        smp();
        while (monitor_ready !== 1'b1 && n < 20) begin
            nxt(); smp(); n++;
        end
        chk(tag, 64'(monitor_ready), 64'd1);
        nxt();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        nxt(); nxt();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] upper_exp;
        reset = 1'b1;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0; jdo = '0;
        clr_jtag();
        for (int i = 0; i < 256; i++) refm[i] = init_val(i);

        // Reset: requests are stalled and never reach the RAM
        avs_read = 1'b1;
        nxt(); nxt();
        smp();
        chk("rst_waitreq", 64'(avs_waitrequest), 64'd1);
        chk("rst_rden", 64'(ram_rden), 64'd0);
        nxt();
        avs_read = 1'b0;
        reset    = 1'b0;
        smp();
        chk("rst_mona", 64'(MonAReg), 64'd0);
        chk("rst_mond", 64'(MonDReg), 64'd0);
        chk("rst_ready", 64'(monitor_ready), 64'd1);
        chk("rst_error", 64'(monitor_error), 64'd0);
        chk("rst_rdata", 64'(avs_readdata), 64'd0);
        chk("rst_waitreq_idle", 64'(avs_waitrequest), 64'd0);
        nxt();

        // JTAG read at 0x10 with exact timing
        set_jtag(0, 8'h10, 0); push_rd(8'h10); push_jrd(8'h10);
        smp(); chk("t1_ready_c0", 64'(monitor_ready), 64'd1);
        nxt(); clr_jtag();
        smp();
        chk("t1_rden_c1", 64'(ram_rden), 64'd1);
        chk("t1_mona_load", 64'(MonAReg), 64'h10);
        chk("t1_busy_c1", 64'(monitor_ready), 64'd0);
        nxt(); smp();
        chk("t1_mona_inc", 64'(MonAReg), 64'h11);
        chk("t1_busy_c2", 64'(monitor_ready), 64'd0);
        nxt(); smp();
        chk("t1_ready_c3", 64'(monitor_ready), 64'd1);
        chk_jrd("t1_mondreg");
        nxt();

        // JTAG writes wrapping past the top of the address space
        set_jtag(0, 8'hFD, 0); push_rd(8'hFD); push_jrd(8'hFD);
        nxt(); clr_jtag();
        wait_ready("t2_load_ready");
        chk_jrd("t2_mond_fd");
        chk("t2_mona_fe", 64'(MonAReg), 64'hFE);
        set_jtag(1, 0, 32'hA5A5A5A5); push_wr(8'hFE, 4'hF, 32'hA5A5A5A5);
        nxt(); clr_jtag();
        smp();
        chk("t2_wren_c1", 64'(ram_wren), 64'd1);
        chk("t2_busy_c1", 64'(monitor_ready), 64'd0);
        nxt(); smp();
        chk("t2_ready_c2", 64'(monitor_ready), 64'd1);
        nxt();
        set_jtag(1, 0, 32'h1); push_wr(8'hFF, 4'hF, 32'h1);
        nxt(); clr_jtag();
        wait_ready("t2_w1_ready");
        set_jtag(1, 0, 32'h2); push_wr(8'h00, 4'hF, 32'h2);
        nxt(); clr_jtag();
        wait_ready("t2_w2_ready");
        chk("t2_mona_wrap", 64'(MonAReg), 64'h01);
        chk("t2_mem_fe", 64'(mem[8'hFE]), 64'hA5A5A5A5);
        chk("t2_mem_ff", 64'(mem[8'hFF]), 64'h1);
        chk("t2_mem_00", 64'(mem[8'h00]), 64'h2);
        set_jtag(0, 8'hFE, 0); push_rd(8'hFE); push_jrd(8'hFE);
        nxt(); clr_jtag();
        wait_ready("t2_rb0_ready"); chk_jrd("t2_rb_fe");
        set_jtag(2, 0, 0); push_rd(8'hFF); push_jrd(8'hFF);
        nxt(); clr_jtag();
        wait_ready("t2_rb1_ready"); chk_jrd("t2_rb_ff");
        set_jtag(2, 0, 0); push_rd(8'h00); push_jrd(8'h00);
        nxt(); clr_jtag();
        wait_ready("t2_rb2_ready"); chk_jrd("t2_rb_00");

        // First tie after reset goes to JTAG
        reset_dut();
        set_jtag(0, 8'h20, 0); push_rd(8'h20); push_jrd(8'h20);
        nxt(); clr_jtag();
        avs_read = 1'b1; avs_address = 8'h30; push_rd(8'h30); push_crd(8'h30);
        smp();
        chk("t3_jtag_first", 64'(ram_address), 64'h20);
        chk("t3_wait_c1", 64'(avs_waitrequest), 64'd1);
        nxt(); smp();
        chk("t3_wait_c2", 64'(avs_waitrequest), 64'd1);
        nxt(); smp();
        chk("t3_wait_c3", 64'(avs_waitrequest), 64'd1);
        chk("t3_cpu_addr", 64'(ram_address), 64'h30);
        nxt(); smp();
        chk("t3_wait_c4", 64'(avs_waitrequest), 64'd0);
        chk_crd("t3_cpu_data");
        chk_jrd("t3_jtag_data");
        nxt();
        avs_read = 1'b0;
        // JTAG write alone, then the next tie goes to the CPU
        set_jtag(1, 0, 32'h12345678); push_wr(8'h21, 4'hF, 32'h12345678);
        nxt(); clr_jtag();
        wait_ready("t3_wr_ready");
        set_jtag(2, 0, 0);
        push_rd(8'h31); push_crd(8'h31); push_rd(8'h22); push_jrd(8'h22);
        nxt(); clr_jtag();
        avs_read = 1'b1; avs_address = 8'h31;
        smp();
        chk("t3b_cpu_wins", 64'(ram_address), 64'h31);
        chk("t3b_wait_c1", 64'(avs_waitrequest), 64'd1);
        nxt(); smp();
        chk("t3b_wait_c2", 64'(avs_waitrequest), 64'd0);
        chk_crd("t3b_cpu_data");
        nxt();
        avs_read = 1'b0;
        smp();
        chk("t3b_jtag_next", 64'(ram_address), 64'h22);
        nxt();
        wait_ready("t3b_jtag_ready");
        chk_jrd("t3b_jtag_data");

        // Command while pending is dropped and flagged
        set_jtag(0, 8'h40, 0); push_rd(8'h40); push_jrd(8'h40);
        nxt();
        set_jtag(2, 0, 0);
        nxt(); clr_jtag();
        smp();
        chk("t4_error_set", 64'(monitor_error), 64'd1);
        chk("t4_mona", 64'(MonAReg), 64'h41);
        nxt();
        wait_ready("t4_ready");
        chk_jrd("t4_mond");
        nxt(); nxt(); nxt();
        chk("t4_mona_once", 64'(MonAReg), 64'h41);
        set_jtag(0, 8'h50, 0); push_rd(8'h50); push_jrd(8'h50);
        nxt(); clr_jtag();
        smp(); chk("t4_error_clr", 64'(monitor_error), 64'd0);
        nxt();
        wait_ready("t4_clr_ready");
        chk_jrd("t4_clr_mond");
        // action_a beats action_b on the same cycle, with no error
        set_jtag(0, 8'h70, 0); take_action_ocimem_b = 1'b1;
        push_rd(8'h70); push_jrd(8'h70);
        nxt(); clr_jtag();
        smp(); chk("t4_prio_err", 64'(monitor_error), 64'd0);
        nxt();
        wait_ready("t4_prio_ready");
        chk_jrd("t4_prio_mond");
        // Pulse on the completion edge is still dropped
        set_jtag(1, 0, 32'h55AA55AA); push_wr(8'h71, 4'hF, 32'h55AA55AA);
        nxt();
        set_jtag(2, 0, 0);
        nxt(); clr_jtag();
        smp();
        chk("t4_edge_err", 64'(monitor_error), 64'd1);
        chk("t4_edge_ready", 64'(monitor_ready), 64'd1);
        chk("t4_edge_mona", 64'(MonAReg), 64'h72);
        nxt(); nxt(); nxt();

        // CPU partial write then read back
        avs_write = 1'b1; avs_address = 8'h05; avs_byteenable = 4'b0011;
        avs_writedata = 32'hDEADBEEF;
        push_wr(8'h05, 4'b0011, 32'hDEADBEEF);
        smp();
        chk("t5_wren", 64'(ram_wren), 64'd1);
        chk("t5_wait", 64'(avs_waitrequest), 64'd0);
        nxt();
        avs_write = 1'b0; avs_read = 1'b1;
        push_rd(8'h05); push_crd(8'h05);
        smp(); chk("t5_rd_wait_c0", 64'(avs_waitrequest), 64'd1);
        nxt(); smp();
        chk("t5_rd_wait_c1", 64'(avs_waitrequest), 64'd0);
        upper_exp = init_val(5);
        chk("t5_upper_kept", 64'(avs_readdata[31:16]), 64'(upper_exp[31:16]));
        chk_crd("t5_rdata");
        nxt();
        avs_read = 1'b0;

        // Reset during the RD_DATA cycle of a JTAG read
        reset_dut();
        set_jtag(0, 8'h60, 0); push_rd(8'h60);
        nxt(); clr_jtag();
        smp(); chk("t6_rden_c1", 64'(ram_rden), 64'd1);
        nxt();
        reset = 1'b1;
        smp(); chk("t6_rden_rst", 64'(ram_rden), 64'd0);
        nxt();
        reset = 1'b0;
        smp();
        chk("t6_strobe_after", 64'({ram_rden, ram_wren}), 64'd0);
        chk("t6_mond", 64'(MonDReg), 64'd0);
        chk("t6_ready", 64'(monitor_ready), 64'd1);
        nxt(); nxt();

        chk("end_ram_q", 64'(ram_q.size()), 64'd0);
        chk("end_jq", 64'(jq.size()), 64'd0);
        chk("end_cq", 64'(cq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios2_ocimem_arbiter.md
# nios2_ocimem_arbiter

Sysclk-domain controller that shares the Nios II on-chip debug memory (OCI RAM, single port, one-cycle read latency) between two requesters. The first is the CPU-side debug-slave Avalon port. The second is the JTAG command stream delivered by the debug slave's sysclk half (`jdo` plus the `take_action_ocimem_*` pulses). It sequences JTAG reads and writes with auto-incrementing address, fairly arbitrates collisions with CPU accesses, and reports `monitor_ready` / `monitor_error` back to the debug slave.

## Interface
Parameters:
- ADDR_WIDTH, 8, OCI RAM word-address width; depth = 2^ADDR_WIDTH 32-bit words.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- avs_address  in  ADDR_WIDTH  CPU word address.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request; wins over `avs_read` if both are high.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU write byte enables.
- avs_readdata  out  32  CPU read data, valid when read completes.
- avs_waitrequest  out  1  stall for the CPU request.
- jdo  in  38  JTAG data: address in jdo[ADDR_WIDTH+25:26], write data in jdo[34:3].
- take_action_ocimem_a  in  1  pulse: load address, clear error, queue read.
- take_no_action_ocimem_a  in  1  pulse: queue read at current address.
- take_action_ocimem_b  in  1  pulse: queue write of jdo[34:3] at current address.
- MonDReg  out  32  last JTAG read data.
- MonAReg  out  ADDR_WIDTH  current JTAG address.
- monitor_ready  out  1  no JTAG operation pending.
- monitor_error  out  1  sticky: JTAG command dropped.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_rden  out  1  RAM read strobe.
- ram_wren  out  1  RAM write strobe.
- ram_byteenable  out  4  RAM byte enables.
- ram_wrdata  out  32  RAM write data.
- ram_rddata  in  32  RAM read data, valid the cycle after `ram_rden`.

## Operation
- State machine: `IDLE` and `RD_DATA`. One access is granted per `IDLE` cycle; the block never grants while in `RD_DATA`, so there is no pipelining.

JTAG command capture (only when no JTAG operation is pending):
- Priority when pulses coincide: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority pulses are ignored without error.
- `take_action_ocimem_a`: MonAReg <= jdo address field; monitor_error <= 0; queue a read.
- `take_action_ocimem_b`: queue a write with data jdo[34:3] and byteenable 4'hF.
- `take_no_action_ocimem_a`: queue a read.
- A queued operation sets `jtag_pending`, so `monitor_ready` = ~`jtag_pending`.
- Any pulse arriving while `jtag_pending` = 1 is dropped, and `monitor_error` is set to 1. MonAReg and the pending operation are unchanged.

Arbitration (in `IDLE`):
- Requesters are `cpu_req` = `avs_read` | `avs_write`, and `jtag_pending`.
- Single requester: it is granted.
- Both requesting: the requester not granted last wins. `last_grant` resets to CPU, so JTAG wins the first tie.

Grant cycle:
- `ram_address` is `avs_address` for the CPU, or MonAReg for JTAG.
- Write: `ram_wren` = 1 with the requester's data and byteenables. The operation completes in the same cycle.
- Read: `ram_rden` = 1, and the next state is `RD_DATA`.
- JTAG grant: MonAReg <= MonAReg + 1, wrapping modulo 2^ADDR_WIDTH.
- JTAG write grant: `jtag_pending` clears at the clock edge.

`RD_DATA` cycle:
- CPU read: `avs_readdata` = `ram_rddata`.
- JTAG read: MonDReg <= `ram_rddata`, and `jtag_pending` clears.
- Next state is `IDLE`.

`avs_waitrequest` = `cpu_req` & ~(CPU write granted this cycle | CPU read in its `RD_DATA` cycle). It is combinational and is forced to 1 while `reset` is high.

`ram_rden` and `ram_wren` are 0 whenever nothing is granted.

## Timing
- Reset values: state `IDLE`, MonAReg 0, MonDReg 0, `monitor_ready` 1, `monitor_error` 0, `last_grant` CPU, `ram_rden`/`ram_wren` 0, `avs_readdata` 0.
- Reset mid-operation: an in-flight read is abandoned and a pending JTAG operation is discarded; no RAM strobe is issued in the cycle after reset.
- CPU write, uncontended: `avs_waitrequest` is low in the request cycle (0 stall).
- CPU read, uncontended: 1 stall cycle; data and `waitrequest`=0 arrive in cycle 1.
- JTAG read: pulse at cycle 0; grant no earlier than cycle 1; MonDReg valid and `monitor_ready` = 1 at cycle 3.
- JTAG write: pulse at cycle 0; grant at cycle 1; `monitor_ready` = 1 at cycle 2.
- Worst-case contention:
  - JTAG waits for at most one CPU access (2 cycles) plus any in-flight `RD_DATA`.
  - CPU waits at most one JTAG access.
- MonAReg wraps from 2^ADDR_WIDTH-1 to 0 without error.
- A pulse that arrives on the same edge a JTAG operation completes is dropped: pending clears at that edge, not before.

## Test plan
- Reset, then JTAG `take_action_ocimem_a` with address 0x10 → MonAReg=0x10, one RAM read at 0x10, MonDReg=RAM[0x10] at cycle 3, MonAReg=0x11, `monitor_ready`=1.
- Three back-to-back `take_action_ocimem_b` writes (0xA5A5A5A5, 0x1, 0x2) starting at MonAReg=0xFE, each spaced until `monitor_ready`=1 → RAM[0xFE]=0xA5A5A5A5, RAM[0xFF]=0x1, RAM[0x00]=0x2; MonAReg=0x01 (wrap).
- CPU read and JTAG read both requesting the first `IDLE` cycle after reset → JTAG granted first; CPU `waitrequest` held 2 extra cycles; on the next tie the CPU wins.
- `take_no_action_ocimem_a` issued while a JTAG read is pending → `monitor_error`=1, single RAM read only, MonAReg +1 only once; a later `take_action_ocimem_a` clears `monitor_error` to 0.
- CPU write with byteenable 4'b0011 and data 0xDEADBEEF to address 0x05 → `ram_wren` and `waitrequest`=0 in the same cycle; a subsequent read returns 0x????BEEF with only the lower bytes changed.
- `reset` asserted during `RD_DATA` of a JTAG read → MonDReg stays 0, `monitor_ready`=1, no strobe in the cycle after reset.
